// File: rtl/alu_operand_stage.sv
// Operand-select / forwarding stage feeding the EX ALU.
// Main output register backed by a one-entry skid so in_ready is a pure flop.
module alu_operand_stage #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned FUNC_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   in_rs1_data,
    input  logic [XLEN-1:0]   in_rs2_data,
    input  logic [XLEN-1:0]   in_imm,
    input  logic [XLEN-1:0]   in_pc,
    input  logic [1:0]        in_op1_sel,
    input  logic              in_op2_sel,
    input  logic [FUNC_W-1:0] in_alu_func,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [4:0]        in_rd,
    input  logic              fwd_mem_en,
    input  logic [4:0]        fwd_mem_rd,
    input  logic [XLEN-1:0]   fwd_mem_data,
    input  logic              fwd_wb_en,
    input  logic [4:0]        fwd_wb_rd,
    input  logic [XLEN-1:0]   fwd_wb_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   op1,
    output logic [XLEN-1:0]   op2,
    output logic [FUNC_W-1:0] ALU_func,
    output logic [4:0]        out_rd
);

    // ALU opcode for ADD in the shared opcode table
    localparam logic [FUNC_W-1:0] FUNC_ADD = FUNC_W'(3);

    logic              main_valid_q, main_valid_d;
    logic [XLEN-1:0]   op1_q, op1_d, op2_q, op2_d;
    logic [FUNC_W-1:0] func_q, func_d;
    logic [4:0]        rd_q, rd_d;

    logic              skid_valid_q, skid_valid_d;
    logic [XLEN-1:0]   skid_op1_q, skid_op1_d, skid_op2_q, skid_op2_d;
    logic [FUNC_W-1:0] skid_func_q, skid_func_d;
    logic [4:0]        skid_rd_q, skid_rd_d;

    logic              in_ready_q, in_ready_d;

    logic [XLEN-1:0]   rs1_fwd, rs2_fwd, beat_op1, beat_op2;
    logic              in_xfer, main_free;

    always_comb begin
        if (fwd_mem_en && fwd_mem_rd == in_rs1 && in_rs1 != 5'd0) begin
            rs1_fwd = fwd_mem_data;
        end else if (fwd_wb_en && fwd_wb_rd == in_rs1 && in_rs1 != 5'd0) begin
            rs1_fwd = fwd_wb_data;
        end else begin
            rs1_fwd = in_rs1_data;
        end

        if (fwd_mem_en && fwd_mem_rd == in_rs2 && in_rs2 != 5'd0) begin
            rs2_fwd = fwd_mem_data;
        end else if (fwd_wb_en && fwd_wb_rd == in_rs2 && in_rs2 != 5'd0) begin
            rs2_fwd = fwd_wb_data;
        end else begin
            rs2_fwd = in_rs2_data;
        end

        unique case (in_op1_sel)
            2'd0:    beat_op1 = rs1_fwd;
            2'd1:    beat_op1 = in_pc;
            default: beat_op1 = '0;
        endcase
        beat_op2 = in_op2_sel ? in_imm : rs2_fwd;
    end

    always_comb begin
        main_valid_d = main_valid_q;
        op1_d        = op1_q;
        op2_d        = op2_q;
        func_d       = func_q;
        rd_d         = rd_q;
        skid_valid_d = skid_valid_q;
        skid_op1_d   = skid_op1_q;
        skid_op2_d   = skid_op2_q;
        skid_func_d  = skid_func_q;
        skid_rd_d    = skid_rd_q;

        in_xfer   = in_valid & in_ready_q;
        main_free = ~main_valid_q | out_ready;

        if (main_free) begin
            if (skid_valid_q) begin
                // Older skid entry always moves up first to keep FIFO order
                main_valid_d = 1'b1;
                op1_d        = skid_op1_q;
                op2_d        = skid_op2_q;
                func_d       = skid_func_q;
                rd_d         = skid_rd_q;
                skid_valid_d = in_xfer;
                if (in_xfer) begin
                    skid_op1_d  = beat_op1;
                    skid_op2_d  = beat_op2;
                    skid_func_d = in_alu_func;
                    skid_rd_d   = in_rd;
                end
            end else begin
                main_valid_d = in_xfer;
                if (in_xfer) begin
                    op1_d  = beat_op1;
                    op2_d  = beat_op2;
                    func_d = in_alu_func;
                    rd_d   = in_rd;
                end
            end
        end else if (in_xfer) begin
            skid_valid_d = 1'b1;
            skid_op1_d   = beat_op1;
            skid_op2_d   = beat_op2;
            skid_func_d  = in_alu_func;
            skid_rd_d    = in_rd;
        end

        // Only valid bits are cleared; data may stay stale
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end

        in_ready_d = ~skid_valid_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid_q <= 1'b0;
            op1_q        <= '0;
            op2_q        <= '0;
            func_q       <= FUNC_ADD;
            rd_q         <= '0;
            skid_valid_q <= 1'b0;
            skid_op1_q   <= '0;
            skid_op2_q   <= '0;
            skid_func_q  <= FUNC_ADD;
            skid_rd_q    <= '0;
            in_ready_q   <= 1'b1;
        end else begin
            main_valid_q <= main_valid_d;
            op1_q        <= op1_d;
            op2_q        <= op2_d;
            func_q       <= func_d;
            rd_q         <= rd_d;
            skid_valid_q <= skid_valid_d;
            skid_op1_q   <= skid_op1_d;
            skid_op2_q   <= skid_op2_d;
            skid_func_q  <= skid_func_d;
            skid_rd_q    <= skid_rd_d;
            in_ready_q   <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = main_valid_q;
    assign op1       = op1_q;
    assign op2       = op2_q;
    assign ALU_func  = func_q;
    assign out_rd    = rd_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Bench for alu_operand_stage: directed vector table, hand sequences, and a
// randomized run against a 2-deep queue reference model.
module tb_alu_operand_stage;

    typedef struct {
        logic [1:0]  op1_sel;
        logic        op2_sel;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] rs1_data, rs2_data, imm, pc;
        logic [3:0]  func;
        logic        mem_en;
        logic [4:0]  mem_rd;
        logic [31:0] mem_data;
        logic        wb_en;
        logic [4:0]  wb_rd;
        logic [31:0] wb_data;
    } beat_t;

    typedef struct {
        logic [31:0] op1, op2;
        logic [3:0]  func;
        logic [4:0]  rd;
    } res_t;

    typedef struct {
        beat_t       b;
        logic [31:0] e1, e2;
    } vec_t;

    logic        clk, rst_n;
    logic        in_valid, in_ready;
    logic [31:0] in_rs1_data, in_rs2_data, in_imm, in_pc;
    logic [1:0]  in_op1_sel;
    logic        in_op2_sel;
    logic [3:0]  in_alu_func;
    logic [4:0]  in_rs1, in_rs2, in_rd;
    logic        fwd_mem_en, fwd_wb_en;
    logic [4:0]  fwd_mem_rd, fwd_wb_rd;
    logic [31:0] fwd_mem_data, fwd_wb_data;
    logic        flush, out_valid, out_ready;
    logic [31:0] op1, op2;
    logic [3:0]  ALU_func;
    logic [4:0]  out_rd;

    int n_cmp = 0;
    int n_err = 0;
    res_t mq[$];

    alu_operand_stage #(.XLEN(32), .FUNC_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
        .in_imm(in_imm), .in_pc(in_pc),
        .in_op1_sel(in_op1_sel), .in_op2_sel(in_op2_sel),
        .in_alu_func(in_alu_func),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
        .fwd_mem_en(fwd_mem_en), .fwd_mem_rd(fwd_mem_rd), .fwd_mem_data(fwd_mem_data),
        .fwd_wb_en(fwd_wb_en), .fwd_wb_rd(fwd_wb_rd), .fwd_wb_data(fwd_wb_data),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .op1(op1), .op2(op2), .ALU_func(ALU_func), .out_rd(out_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: forwarding priority MEM > WB > regfile, x0 never forwarded
    function automatic res_t ref_eval(input beat_t b);
        res_t r;
        logic [31:0] s1, s2;
        if (b.mem_en && b.mem_rd == b.rs1 && b.rs1 != 0) s1 = b.mem_data;
        else if (b.wb_en && b.wb_rd == b.rs1 && b.rs1 != 0) s1 = b.wb_data;
        else s1 = b.rs1_data;
        if (b.mem_en && b.mem_rd == b.rs2 && b.rs2 != 0) s2 = b.mem_data;
        else if (b.wb_en && b.wb_rd == b.rs2 && b.rs2 != 0) s2 = b.wb_data;
        else s2 = b.rs2_data;
        r.op1  = (b.op1_sel == 2'd0) ? s1 : (b.op1_sel == 2'd1) ? b.pc : 32'd0;
        r.op2  = b.op2_sel ? b.imm : s2;
        r.func = b.func;
        r.rd   = b.rd;
        return r;
    endfunction

    function automatic beat_t zero_beat();
        beat_t b;
        b.op1_sel = 0; b.op2_sel = 0; b.rs1 = 0; b.rs2 = 0; b.rd = 0;
        b.rs1_data = 0; b.rs2_data = 0; b.imm = 0; b.pc = 0; b.func = 0;
        b.mem_en = 0; b.mem_rd = 0; b.mem_data = 0;
        b.wb_en = 0; b.wb_rd = 0; b.wb_data = 0;
        return b;
    endfunction

    function automatic beat_t tag_beat(input int t);
        beat_t b = zero_beat();
        b.rs1_data = 32'(t);
        b.op2_sel  = 1'b1;
        b.imm      = 32'(t * 16);
        b.func     = 4'(t);
        b.rd       = 5'(t);
        return b;
    endfunction

    function automatic beat_t rand_beat();
        beat_t b;
        b.op1_sel = 2'($urandom_range(0, 3)); b.op2_sel = 1'($urandom_range(0, 1));
        b.rs1 = 5'($urandom_range(0, 3)); b.rs2 = 5'($urandom_range(0, 3));
        b.rd = 5'($urandom); b.func = 4'($urandom);
        b.rs1_data = $urandom; b.rs2_data = $urandom; b.imm = $urandom; b.pc = $urandom;
        b.mem_en = 1'($urandom_range(0, 1)); b.mem_rd = 5'($urandom_range(0, 3));
        b.mem_data = $urandom;
        b.wb_en = 1'($urandom_range(0, 1)); b.wb_rd = 5'($urandom_range(0, 3));
        b.wb_data = $urandom;
        return b;
    endfunction

    function automatic vec_t mkv(input logic [1:0] s1, input logic s2,
                                 input logic [4:0] r1, input logic [4:0] r2,
                                 input logic [31:0] d1, input logic [31:0] d2,
                                 input logic [31:0] imm, input logic [31:0] pc,
                                 input logic men, input logic [4:0] mrd, input logic [31:0] mdat,
                                 input logic wen, input logic [4:0] wrd, input logic [31:0] wdat,
                                 input logic [31:0] e1, input logic [31:0] e2);
        vec_t v;
        v.b = zero_beat();
        v.b.op1_sel = s1; v.b.op2_sel = s2; v.b.rs1 = r1; v.b.rs2 = r2;
        v.b.rs1_data = d1; v.b.rs2_data = d2; v.b.imm = imm; v.b.pc = pc;
        v.b.mem_en = men; v.b.mem_rd = mrd; v.b.mem_data = mdat;
        v.b.wb_en = wen; v.b.wb_rd = wrd; v.b.wb_data = wdat;
        v.b.func = 4'd3; v.b.rd = 5'd9;
        v.e1 = e1; v.e2 = e2;
        return v;
    endfunction

    task automatic check_state();
        chk("out_valid", 32'(out_valid), 32'(mq.size() > 0));
        chk("in_ready", 32'(in_ready), 32'(mq.size() < 2));
        if (mq.size() > 0) begin
            chk("op1", op1, mq[0].op1);
            chk("op2", op2, mq[0].op2);
            chk("ALU_func", 32'(ALU_func), 32'(mq[0].func));
            chk("out_rd", 32'(out_rd), 32'(mq[0].rd));
        end
    endtask

    // Called at a negedge: drive, advance the model, clock, then check.
    task automatic do_cycle(input beat_t b, input logic v, input logic ordy,
                            input logic fl, output logic acc);
        in_valid = v; out_ready = ordy; flush = fl;
        in_op1_sel = b.op1_sel; in_op2_sel = b.op2_sel;
        in_rs1 = b.rs1; in_rs2 = b.rs2; in_rd = b.rd;
        in_rs1_data = b.rs1_data; in_rs2_data = b.rs2_data;
        in_imm = b.imm; in_pc = b.pc; in_alu_func = b.func;
        fwd_mem_en = b.mem_en; fwd_mem_rd = b.mem_rd; fwd_mem_data = b.mem_data;
        fwd_wb_en = b.wb_en; fwd_wb_rd = b.wb_rd; fwd_wb_data = b.wb_data;
        acc = v && (mq.size() < 2);
        if (fl) begin
            mq.delete();
        end else begin
            if (ordy && mq.size() > 0) void'(mq.pop_front());
            if (acc) mq.push_back(ref_eval(b));
        end
        @(posedge clk);
        @(negedge clk);
        check_state();
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        chk({tag, "_op1"}, op1, 32'd0);
        chk({tag, "_op2"}, op2, 32'd0);
        chk({tag, "_func"}, 32'(ALU_func), 32'd3);
        chk({tag, "_rd"}, 32'(out_rd), 32'd0);
    endtask

    initial begin
        vec_t tbl[8];
        logic acc;
        beat_t zb;
        int emerged[$];
        int tag;

        tbl[0] = mkv(0, 1, 1, 0, 5, 0, 7, 0, 0, 0, 0, 0, 0, 0, 32'd5, 32'd7);
        tbl[1] = mkv(0, 1, 3, 0, 0, 0, 1, 0, 1, 3, 32'hAAAA, 1, 3, 32'hBBBB, 32'hAAAA, 32'd1);
        tbl[2] = mkv(0, 1, 3, 0, 0, 0, 1, 0, 0, 3, 32'hAAAA, 1, 3, 32'hBBBB, 32'hBBBB, 32'd1);
        tbl[3] = mkv(0, 1, 0, 0, 0, 0, 1, 0, 1, 0, 32'hAAAA, 1, 0, 32'hBBBB, 32'd0, 32'd1);
        tbl[4] = mkv(1, 0, 2, 4, 9, 32'h22, 0, 32'h1000, 0, 0, 0, 1, 4, 32'h44, 32'h1000, 32'h44);
        tbl[5] = mkv(2, 0, 1, 5, 9, 32'h55, 0, 32'h2000, 1, 6, 32'h66, 0, 0, 0, 32'd0, 32'h55);
        tbl[6] = mkv(3, 0, 1, 0, 9, 32'h12, 0, 32'h3000, 1, 0, 32'hDEAD, 0, 0, 0, 32'd0, 32'h12);
        tbl[7] = mkv(0, 1, 7, 0, 32'h70, 0, 32'hFFFF_FFFF, 0, 1, 8, 32'h88, 1, 7, 32'h77,
                     32'h77, 32'hFFFF_FFFF);
        zb = zero_beat();

        rst_n = 1'b0; in_valid = 0; out_ready = 1; flush = 0;
        in_op1_sel = 0; in_op2_sel = 0; in_rs1 = 0; in_rs2 = 0; in_rd = 0;
        in_rs1_data = 0; in_rs2_data = 0; in_imm = 0; in_pc = 0; in_alu_func = 0;
        fwd_mem_en = 0; fwd_mem_rd = 0; fwd_mem_data = 0;
        fwd_wb_en = 0; fwd_wb_rd = 0; fwd_wb_data = 0;
        repeat (2) @(negedge clk);
        check_reset_values("reset");
        rst_n = 1'b1;

        // Directed vectors, each from an empty stage with out_ready high
        foreach (tbl[i]) begin
            do_cycle(tbl[i].b, 1, 1, 0, acc);
            chk($sformatf("vec%0d_op1", i), op1, tbl[i].e1);
            chk($sformatf("vec%0d_op2", i), op2, tbl[i].e2);
            chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'd1);
            do_cycle(zb, 0, 1, 0, acc);
        end

        // Backpressure: beats 1..4, out_ready low from the second cycle
        do_cycle(tag_beat(1), 1, 1, 0, acc);
        do_cycle(tag_beat(2), 1, 0, 0, acc);
        chk("bp_in_ready_low", 32'(in_ready), 32'd0);
        chk("bp_main_tag", 32'(out_rd), 32'd1);
        do_cycle(tag_beat(3), 1, 0, 0, acc);
        chk("bp_beat3_refused", 32'(acc), 32'd0);
        chk("bp_held_op2", op2, 32'd16);
        tag = 3;
        for (int c = 0; c < 20 && emerged.size() < 4; c++) begin
            if (out_valid) emerged.push_back(int'(out_rd));
            do_cycle(tag_beat(tag), tag <= 4, 1, 0, acc);
            if (acc) tag++;
        end
        chk("bp_emerged_count", 32'(emerged.size()), 32'd4);
        for (int k = 0; k < emerged.size() && k < 4; k++)
            chk($sformatf("bp_order%0d", k), 32'(emerged[k]), 32'(k + 1));
        do_cycle(zb, 0, 1, 0, acc);

        // Flush with both entries full plus an incoming beat
        do_cycle(tag_beat(5), 1, 0, 0, acc);
        do_cycle(tag_beat(6), 1, 0, 0, acc);
        do_cycle(tag_beat(7), 1, 0, 1, acc);
        chk("flush_full_valid", 32'(out_valid), 32'd0);
        chk("flush_full_ready", 32'(in_ready), 32'd1);
        // Flush while a beat is accepted in the same cycle
        do_cycle(tag_beat(8), 1, 0, 0, acc);
        do_cycle(tag_beat(9), 1, 0, 1, acc);
        chk("flush_accept_valid", 32'(out_valid), 32'd0);
        repeat (3) do_cycle(zb, 0, 1, 0, acc);

        // Asynchronous reset between clock edges with data in flight
        do_cycle(tag_beat(10), 1, 0, 0, acc);
        do_cycle(tag_beat(11), 1, 0, 0, acc);
        #2 rst_n = 1'b0;
        #1 check_reset_values("async");
        mq.delete();
        @(negedge clk);
        rst_n = 1'b1;
        do_cycle(tbl[0].b, 1, 1, 0, acc);
        chk("post_reset_op1", op1, 32'd5);
        chk("post_reset_op2", op2, 32'd7);
        chk("post_reset_ready", 32'(in_ready), 32'd1);

        // Randomized valid/ready/flush traffic against the queue model
        for (int c = 0; c < 10000; c++) begin
            do_cycle(rand_beat(), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0),
                     1'($urandom_range(0, 31) == 0), acc);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
